// File: rtl/gray_binary_converter_pipelined.sv
// -----------------------------------------------------------------------------
// gray_binary_converter_pipelined
//
// Bidirectional Gray <-> unsigned binary converter, selectable per word.
// Gray-to-binary is an MSB-to-LSB XOR prefix chain; the chain is cut into
// STAGES register slices of SLICE = ceil(WORD_WIDTH/STAGES) bits so wide
// words still close timing. Binary-to-Gray is done entirely in stage 0 and
// the word then rides through the remaining stages, so both modes share the
// same latency (STAGES cycles) and ordering is preserved across mode changes.
//
// Ports:
//   clock         single clock, rising edge
//   clear         synchronous active-high reset, discards all in-flight words
//   input_valid   input word present
//   input_ready   block accepts input this cycle (combinational from output_ready)
//   input_mode    0 = Gray to binary, 1 = binary to Gray
//   input_data    word to convert
//   output_valid  converted word present (registered)
//   output_ready  downstream accepts output this cycle
//   output_data   converted word (registered)
//   output_mode   input_mode of the word on output_data (registered)
// -----------------------------------------------------------------------------
module gray_binary_converter_pipelined #(
  parameter int WORD_WIDTH = 32,
  parameter int STAGES     = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic                  input_mode,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data,
  output logic                  output_mode
);

  localparam int SLICE = (WORD_WIDTH + STAGES - 1) / STAGES;

  // Stage registers. r_data holds the partially converted word: in Gray mode
  // the bits above the current slice are already binary and the bits below
  // are still the original Gray bits, so the original word is carried along
  // inside it.
  logic [STAGES-1:0]     r_valid;
  logic [STAGES-1:0]     r_mode;
  logic [WORD_WIDTH-1:0] r_data [STAGES];

  logic [STAGES-1:0]     w_load;
  logic [STAGES-1:0]     w_src_valid;
  logic [STAGES-1:0]     w_src_mode;
  logic [WORD_WIDTH-1:0] w_src_data  [STAGES];
  logic [WORD_WIDTH-1:0] w_next_data [STAGES];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // A stage can load unless it and every stage after it are full while
      // the output is stalled; this is the unrolled form of
      // load_k = !valid_k || load_(k+1), which lets bubbles collapse.
      assign w_load[k] = output_ready | ~(&r_valid[STAGES-1:k]);

      if (k == 0) begin : g_first
        assign w_src_valid[k] = input_valid;
        assign w_src_mode[k]  = input_mode;
        assign w_src_data[k]  = input_data;
      end else begin : g_rest
        assign w_src_valid[k] = r_valid[k-1];
        assign w_src_mode[k]  = r_mode[k-1];
        assign w_src_data[k]  = r_data[k-1];
      end
    end
  endgenerate

  // Per-stage conversion of the word about to be loaded into each stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_next_data[k] = w_src_data[k];
      if (w_src_mode[k] == 1'b0) begin
        // Bits inside this stage's slice extend the prefix chain; the bit
        // just above the slice was resolved by an earlier stage (or is the
        // MSB, which is identical in both codes). Stages past the end of the
        // word have an empty slice and pass the word through.
        for (int i = WORD_WIDTH - 2; i >= 0; i--) begin
          if ((i <= WORD_WIDTH - 1 - k * SLICE) && (i >= WORD_WIDTH - (k + 1) * SLICE)) begin
            w_next_data[k][i] = w_next_data[k][i + 1] ^ w_src_data[k][i];
          end else begin
            w_next_data[k][i] = w_src_data[k][i];
          end
        end
      end else if (k == 0) begin
        w_next_data[k] = w_src_data[k] ^ (w_src_data[k] >> 32'd1);
      end else begin
        w_next_data[k] = w_src_data[k];
      end
    end
  end

  // Pipeline state: clear empties everything, otherwise each stage loads
  // from its source whenever it is allowed to.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_valid <= '0;
      r_mode  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_src_valid[k];
          // Payload only moves with a real word, keeping idle stages quiet.
          if (w_src_valid[k]) begin
            r_mode[k] <= w_src_mode[k];
            r_data[k] <= w_next_data[k];
          end
        end
      end
    end
  end

  assign input_ready  = w_load[0] & ~clear;
  assign output_valid = r_valid[STAGES-1];
  assign output_mode  = r_mode[STAGES-1];
  assign output_data  = r_data[STAGES-1];

endmodule

// File: tb/tb_gray_binary_converter_pipelined.sv
module tb_gray_binary_converter_pipelined;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference conversion from the code definitions: Gray = b ^ (b >> 1),
  // binary = XOR of the Gray word shifted right by every amount.
  function automatic logic [31:0] ref_conv(input logic m, input logic [31:0] x);
    logic [31:0] r;
    r = 32'd0;
    if (m) r = x ^ (x >> 1);
    else for (int s = 0; s < 32; s++) r = r ^ (x >> s);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed instance: W=8, S=3
  // ---------------------------------------------------------------------------
  logic       d_clr, d_iv, d_ir, d_im, d_ov, d_ordy, d_om;
  logic [7:0] d_id, d_od;
  bit         d_done = 1'b0;

  typedef struct { logic [8:0] v; int cyc; bit lat; } d_ent_t;
  d_ent_t d_q[$];

  gray_binary_converter_pipelined #(.WORD_WIDTH(8), .STAGES(3)) u_dir (
    .clock(clock), .clear(d_clr),
    .input_valid(d_iv), .input_ready(d_ir), .input_mode(d_im), .input_data(d_id),
    .output_valid(d_ov), .output_ready(d_ordy), .output_data(d_od), .output_mode(d_om)
  );

  // Directed monitor: pops on output transfer, checks value, latency, stall hold.
  logic [8:0] d_last;
  bit         d_last_stall = 1'b0;
  always @(negedge clock) begin
    d_ent_t e;
    if (d_clr) begin
      d_last_stall = 1'b0;
    end else begin
      if (d_last_stall) check("dir_stall_hold", 64'({d_ov, d_om, d_od}), 64'({1'b1, d_last}));
      if (d_ov && d_ordy) begin
        if (d_q.size() == 0) begin
          n_total++;
          $display("FAIL dir_spurious: got %0h expected no output", {d_om, d_od});
        end else begin
          e = d_q.pop_front();
          check("dir_out", 64'({d_om, d_od}), 64'(e.v));
          if (e.lat) check("dir_latency", 64'(cyc - e.cyc), 64'd3);
        end
      end
      d_last_stall = d_ov && !d_ordy;
      d_last = {d_om, d_od};
    end
  end

  task automatic d_send(input logic m, input logic [7:0] d, input logic [7:0] e, input bit lat);
    bit acc;
    int waited;
    d_ent_t ent;
    d_iv = 1'b1; d_im = m; d_id = d; waited = 0;
    do begin
      @(negedge clock);
      acc = d_ir;
      if (acc) begin
        ent.v = {m, e}; ent.cyc = cyc; ent.lat = lat;
        d_q.push_back(ent);
      end
      @(posedge clock); #1;
      waited++;
    end while (!acc && waited < 100);
    if (!acc) check("dir_accept_timeout", 64'(acc), 64'd1);
    d_iv = 1'b0;
  endtask

  logic [8:0] dir_tab [10] = '{
    {1'b0, 8'hC0}, {1'b0, 8'h80}, {1'b0, 8'h00}, {1'b1, 8'h80}, {1'b1, 8'hFF},
    {1'b0, 8'h0F}, {1'b1, 8'h0F}, {1'b0, 8'h55}, {1'b1, 8'h55}, {1'b0, 8'hFF}
  };
  logic [7:0] dir_exp [10] = '{8'h80, 8'hFF, 8'h00, 8'hC0, 8'h80, 8'h0A, 8'h08, 8'h66, 8'h7F, 8'hAA};

  initial begin
    logic [7:0] bw [10];
    logic       bm [10];
    logic [31:0] e32;
    int sent;
    d_ent_t ent;
    d_clr = 1'b1; d_iv = 1'b0; d_im = 1'b0; d_id = 8'h00; d_ordy = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("dir_rst_ov", 64'(d_ov), 64'd0);
    check("dir_rst_od", 64'(d_od), 64'd0);
    check("dir_rst_om", 64'(d_om), 64'd0);
    check("dir_rst_ir", 64'(d_ir), 64'd0);
    @(posedge clock); #1;
    d_clr = 1'b0;

    // Isolated words, then alternating modes back-to-back.
    for (int i = 0; i < 5; i++) begin
      d_send(dir_tab[i][8], dir_tab[i][7:0], dir_exp[i], 1'b1);
      repeat (5) @(posedge clock);
      #1;
    end
    for (int i = 5; i < 10; i++) d_send(dir_tab[i][8], dir_tab[i][7:0], dir_exp[i], 1'b1);
    repeat (6) @(posedge clock);
    #1;

    // Backpressure: output stalled from an empty pipe, ready must fall only
    // once all three stages hold a word; stream resumes afterwards.
    for (int i = 0; i < 10; i++) begin bw[i] = 8'($urandom); bm[i] = 1'($urandom_range(1)); end
    sent = 0;
    d_ordy = 1'b0;
    for (int k = 0; k < 40 && sent < 10; k++) begin
      d_iv = 1'b1; d_im = bm[sent]; d_id = bw[sent];
      @(negedge clock);
      if (k < 6) check("dir_ready_fill", 64'(d_ir), 64'(sent < 3));
      if (d_ir) begin
        e32 = ref_conv(bm[sent], 32'(bw[sent]));
        ent.v = {bm[sent], e32[7:0]}; ent.cyc = cyc; ent.lat = 1'b0;
        d_q.push_back(ent);
        sent++;
      end
      @(posedge clock); #1;
      d_ordy = (k >= 5);
    end
    d_iv = 1'b0; d_ordy = 1'b1;
    check("dir_bp_sent", 64'(sent), 64'd10);
    repeat (8) @(posedge clock);
    #1;
    check("dir_bp_drained", 64'(d_q.size()), 64'd0);

    // Clear with three words in flight: none may ever appear.
    d_ordy = 1'b0;
    d_send(1'b0, 8'h12, 8'h00, 1'b0);
    d_send(1'b1, 8'h34, 8'h00, 1'b0);
    d_send(1'b0, 8'h56, 8'h00, 1'b0);
    d_clr = 1'b1; d_ordy = 1'b1;
    @(negedge clock);
    check("dir_ready_in_clear", 64'(d_ir), 64'd0);
    @(posedge clock); #1;
    d_clr = 1'b0;
    d_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("dir_no_emit_after_clear", 64'(d_ov), 64'd0);
    end
    @(posedge clock); #1;
    d_send(1'b0, 8'hC0, 8'h80, 1'b1);
    repeat (6) @(posedge clock);
    #1;
    check("dir_final_drained", 64'(d_q.size()), 64'd0);
    d_done = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboarded random instances: W=8 with S=1,3,5,8 (exhaustive round trip
  // first) and W=32, S=4 with 10k words.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < 5; c++) begin : g_cfg
    localparam int W     = (c == 4) ? 32 : 8;
    localparam int S     = (c == 0) ? 1 : (c == 1) ? 3 : (c == 2) ? 5 : (c == 3) ? 8 : 4;
    localparam int NRAND = (c == 4) ? 10000 : 600;

    logic         clr, iv, ir, im, ov, ordy, om;
    logic [W-1:0] id, od;
    logic [W:0]   exp_q[$];
    logic [W:0]   last_out;
    logic [W-1:0] prev_gray;
    bit           last_stall = 1'b0;
    bit           exh = 1'b0;
    bit           done = 1'b0;
    int           n_seq = 0;
    int           bp = 0;

    gray_binary_converter_pipelined #(.WORD_WIDTH(W), .STAGES(S)) u_dut (
      .clock(clock), .clear(clr),
      .input_valid(iv), .input_ready(ir), .input_mode(im), .input_data(id),
      .output_valid(ov), .output_ready(ordy), .output_data(od), .output_mode(om)
    );

    // Monitor: pop/compare on output transfer, then record accepted inputs.
    always @(negedge clock) begin
      logic [31:0] e;
      logic [W:0]  want;
      if (clr) begin
        exp_q.delete();
        last_stall = 1'b0;
      end else begin
        if (last_stall) check($sformatf("cfg%0d_stall_hold", c), 64'({ov, om, od}), 64'({1'b1, last_out}));
        if (ov && ordy) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL cfg%0d_spurious: got %0h expected no output", c, {om, od});
          end else begin
            want = exp_q.pop_front();
            check($sformatf("cfg%0d_out", c), 64'({om, od}), 64'(want));
          end
          if (om && exh && n_seq < 256) begin
            if (n_seq > 0) check($sformatf("cfg%0d_gray_one_bit", c), 64'($countones(od ^ prev_gray)), 64'd1);
            prev_gray = od;
            n_seq++;
          end
        end
        if (iv && ir) begin
          e = ref_conv(im, 32'(id));
          exp_q.push_back({im, e[W-1:0]});
        end
        last_stall = ov && !ordy;
        last_out = {om, od};
      end
    end

    task automatic idle();
      @(posedge clock); #1;
      ordy = (32'($urandom_range(99)) >= 32'(bp));
    endtask

    task automatic send(input logic m, input logic [W-1:0] d);
      bit acc;
      int waited;
      iv = 1'b1; im = m; id = d; waited = 0;
      do begin
        @(negedge clock);
        acc = ir;
        @(posedge clock); #1;
        ordy = (32'($urandom_range(99)) >= 32'(bp));
        waited++;
      end while (!acc && waited < 1000);
      if (!acc) check($sformatf("cfg%0d_accept_timeout", c), 64'(acc), 64'd1);
      iv = 1'b0;
    endtask

    initial begin
      int waited;
      clr = 1'b1; iv = 1'b0; im = 1'b0; id = '0; ordy = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check($sformatf("cfg%0d_rst_ov", c), 64'(ov), 64'd0);
      check($sformatf("cfg%0d_rst_od", c), 64'(od), 64'd0);
      check($sformatf("cfg%0d_rst_ir", c), 64'(ir), 64'd0);
      @(posedge clock); #1;
      clr = 1'b0;
      if (W == 8) begin
        exh = 1'b1;
        for (int v = 0; v < 256; v++) send(1'b1, W'(v));
        for (int v = 0; v < 256; v++) send(1'b0, W'(v ^ (v >> 1)));
      end
      bp = 30;
      for (int i = 0; i < NRAND; i++) begin
        send(1'($urandom_range(1)), W'($urandom));
        repeat ($urandom_range(1)) idle();
      end
      bp = 0; ordy = 1'b1; waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
        @(posedge clock); #1;
        waited++;
      end
      check($sformatf("cfg%0d_drained", c), 64'(exp_q.size()), 64'd0);
      done = 1'b1;
    end
  end

  // Completion watchdog and summary.
  initial begin
    int w;
    w = 0;
    while (!(d_done && g_cfg[0].done && g_cfg[1].done && g_cfg[2].done &&
             g_cfg[3].done && g_cfg[4].done) && w < 90000) begin
      @(posedge clock);
      w++;
    end
    if (w >= 90000) begin
      n_total++;
      $display("FAIL watchdog: got timeout after %0d cycles expected all streams done", w);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
